// File: rtl/trace_pkg.sv
// Shared definitions for the retirement trace transmitter: FSM states,
// commit-record layout and word1 field positions.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PC   = 2'd1,
        INFO = 2'd2,
        DATA = 2'd3
    } trace_state_t;

    // Commit record layout: {pc[31:0], we, rd[4:0], wdata[31:0]}
    localparam int REC_W      = 70;
    localparam int REC_PC_MSB = 69;
    localparam int REC_PC_LSB = 38;
    localparam int REC_WE_BIT = 37;
    localparam int REC_RD_MSB = 36;
    localparam int REC_RD_LSB = 32;
    localparam int REC_WD_MSB = 31;
    localparam int REC_WD_LSB = 0;

    // word1 layout: {we, 26'b0, rd}
    localparam int INFO_WE_BIT = 31;
    localparam int INFO_RD_MSB = 4;
    localparam int INFO_RD_LSB = 0;

    typedef logic [REC_W-1:0] trace_rec_t;

    // Assemble one commit record from the retirement fields.
    function automatic trace_rec_t pack_rec(input logic [31:0] pc,
                                            input logic        we,
                                            input logic [4:0]  rd,
                                            input logic [31:0] wdata);
        return {pc, we, rd, wdata};
    endfunction

    // Build word1 from the we/rd fields of a record (pc part not needed).
    function automatic logic [31:0] info_word(input logic        we,
                                              input logic [4:0]  rd);
        logic [31:0] w;
        w = 32'd0;
        w[INFO_WE_BIT] = we;
        w[INFO_RD_MSB:INFO_RD_LSB] = rd;
        return w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Commit-record FIFO. Head entry is visible on dout while not empty
// (show-ahead). Pointers carry one extra wrap bit to tell full from empty.
import trace_pkg::*;

module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = REC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and qualified push/pop.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        dout      = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Pointer update; both may advance on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage write; contents need no reset since empty gates the reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/trace_tx.sv
// Retirement trace transmitter: buffers commit records and serialises each
// into a 2- or 3-word packet on a valid/ready stream, counting drops.
// Optional macro TRACE_FILTER_EN: ignore commits with commit_we=0 or
// commit_rd=0 (neither recorded nor counted as drops).
import trace_pkg::*;

module trace_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit_valid,
    input  logic [31:0]      commit_pc,
    input  logic             commit_we,
    input  logic [4:0]       commit_rd,
    input  logic [31:0]      commit_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    trace_state_t          state_r;
    logic [REC_PC_LSB-1:0] pkt_r;       // we, rd, wdata of the packet in flight
    logic                  out_valid_r;
    logic [31:0]           out_data_r;
    logic                  out_last_r;
    logic                  overflow_r;
    logic [CNT_W-1:0]      drop_count_r;

    trace_rec_t            head_s;
    trace_rec_t            rec_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  rec_en_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;
    logic                  hs_s;

    // Record qualification, push/drop decision and pop request.
    always_comb begin
`ifdef TRACE_FILTER_EN
        rec_en_s = commit_valid && commit_we && (commit_rd != 5'd0);
`else
        rec_en_s = commit_valid;
`endif
        rec_s  = pack_rec(commit_pc, commit_we, commit_rd, commit_wdata);
        push_s = rec_en_s && !full_s;
        drop_s = rec_en_s && full_s;
        hs_s   = out_valid_r && out_ready;
        // Pop when idle, or on the handshake of a packet's last word so
        // the next packet follows without a gap.
        pop_s  = !empty_s && ((state_r == IDLE) || (hs_s && out_last_r));
    end

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (rec_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Packet FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pkt_r       <= {REC_PC_LSB{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        state_r     <= PC;
                        pkt_r       <= head_s[REC_PC_LSB-1:0];
                        out_valid_r <= 1'b1;
                        out_data_r  <= head_s[REC_PC_MSB:REC_PC_LSB];
                        out_last_r  <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                    end
                end
                PC: begin
                    if (hs_s) begin
                        state_r    <= INFO;
                        out_data_r <= info_word(pkt_r[REC_WE_BIT],
                                                pkt_r[REC_RD_MSB:REC_RD_LSB]);
                        out_last_r <= ~pkt_r[REC_WE_BIT];
                    end else begin
                        state_r <= PC;
                    end
                end
                INFO: begin
                    if (hs_s) begin
                        if (pkt_r[REC_WE_BIT]) begin
                            state_r    <= DATA;
                            out_data_r <= pkt_r[REC_WD_MSB:REC_WD_LSB];
                            out_last_r <= 1'b1;
                        end else if (pop_s) begin
                            state_r     <= PC;
                            pkt_r       <= head_s[REC_PC_LSB-1:0];
                            out_data_r  <= head_s[REC_PC_MSB:REC_PC_LSB];
                            out_last_r  <= 1'b0;
                        end else begin
                            state_r     <= IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= INFO;
                    end
                end
                DATA: begin
                    if (hs_s) begin
                        if (pop_s) begin
                            state_r     <= PC;
                            pkt_r       <= head_s[REC_PC_LSB-1:0];
                            out_data_r  <= head_s[REC_PC_MSB:REC_PC_LSB];
                            out_last_r  <= 1'b0;
                        end else begin
                            state_r     <= IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r   <= 1'b0;
            drop_count_r <= {CNT_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_count_r != CNT_MAX) begin
                drop_count_r <= drop_count_r + CNT_ONE;
            end else begin
                drop_count_r <= drop_count_r;
            end
        end else begin
            overflow_r   <= overflow_r;
            drop_count_r <= drop_count_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: doc/trace_tx.md
TRACE_TX -- requirements
Module: trace_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning commit-record FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning drop-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port commit_valid  input  1  one instruction retired this cycle.
REQ-006 SHALL have port commit_pc  input  32  PC of the retired instruction.
REQ-007 SHALL have port commit_we  input  1  retired instruction writes the register file.
REQ-008 SHALL have port commit_rd  input  5  destination register index.
REQ-009 SHALL have port commit_wdata  input  32  value written to commit_rd.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid trace word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the word this cycle.
REQ-012 SHALL have port out_data  output  32  trace word.
REQ-013 SHALL have port out_last  output  1  final word of the current packet.
REQ-014 SHALL have port overflow  output  1  sticky: at least one record dropped.
REQ-015 SHALL have port drop_count  output  CNT_W  number of dropped records, saturating.

Function
REQ-016 SHALL push {pc, we, rd, wdata} into the FIFO on each clock edge where commit_valid=1 and the FIFO is not full.
REQ-017 SHALL drop the record when commit_valid=1 and the FIFO is full, even if a pop occurs in the same cycle.
REQ-018 SHALL set overflow and increment drop_count on every drop, with drop_count holding at all-ones.
REQ-019 SHALL emit each record as one packet: word0=pc, word1={we, 26'b0, rd}, word2=wdata only when we=1.
REQ-020 SHALL assert out_last on word2 when we=1, and on word1 when we=0.
REQ-021 SHALL use FSM states IDLE, PC, INFO, DATA.
REQ-022 SHALL transition IDLE->PC when the FIFO is non-empty, popping the head into a packet register.
REQ-023 SHALL transition PC->INFO on handshake.
REQ-024 SHALL transition INFO->DATA on handshake when we=1, and INFO->PC (FIFO non-empty) or INFO->IDLE (empty) when we=0.
REQ-025 SHALL transition DATA->PC (FIFO non-empty) or DATA->IDLE (empty) on handshake.
REQ-026 SHALL pop the next record on the same edge as a last-word handshake, so packets are back-to-back with no idle cycle.
REQ-027 SHALL define handshake as out_valid=1 and out_ready=1 on a rising edge.
REQ-028 SHALL hold out_valid high and out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-029 SHALL hold out_valid high in states PC, INFO and DATA, and low in IDLE.
REQ-030 SHALL give first-word latency from an empty FIFO as: commit sampled at edge N -> out_valid=1 after edge N+1.
REQ-031 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with full/empty derived from an extra pointer bit.
REQ-032 SHALL allow push and pop in the same cycle when the FIFO is neither full nor empty.

Reset
REQ-033 SHALL, while rst_n=0 at an edge, set state=IDLE, empty the FIFO, and drive out_valid=0, out_data=0, out_last=0, overflow=0, drop_count=0.
REQ-034 SHALL discard a partly sent packet when reset is asserted mid-packet, with no resumption after reset.
REQ-035 SHALL not record commits sampled while rst_n=0.

Configuration
REQ-036 SHALL, with TRACE_FILTER_EN defined, ignore commits with commit_we=0 or commit_rd=0: they are not recorded and are not counted as drops.
REQ-037 SHALL, without TRACE_FILTER_EN, record every commit.

Structure
REQ-038 SHALL place the FSM state enum, the record width (70 bits), and the word1 field positions in shared package trace_pkg.
REQ-039 SHALL implement the FIFO as sub-module trace_fifo with push/pop/full/empty ports; trace_tx holds the FSM, counters and output register.

Verification
REQ-040 SHALL check: single commit pc=0x00400000, we=1, rd=16, wdata=0x0000000A, out_ready=1 -> words 0x00400000, 0x80000010, 0x0000000A; last on word 3; first word valid 2 cycles after commit.
REQ-041 SHALL check: commit with we=0, pc=0x00400004, rd=0 -> two words 0x00400004, 0x00000000 with last on word 2 (without TRACE_FILTER_EN); no output with it defined.
REQ-042 SHALL check: 6 consecutive we=1 commits with out_ready=0, FIFO_DEPTH=4 -> 4 stored (one already in the packet register, so 5 retained); overflow=1; drop_count=1; 15 words after out_ready=1.
REQ-043 SHALL check: out_ready toggled every cycle mid-packet -> out_data is unchanged across stalled cycles and no word is duplicated or lost.
REQ-044 SHALL check: rst_n=0 for one cycle during word2 -> out_valid=0 next cycle, drop_count=0, and the next commit produces a fresh packet starting with its pc.
REQ-045 SHALL check: back-to-back commits every cycle with out_ready=1 -> continuous out_valid, and packets separated only by out_last.
